// File: rtl/mem_access_if.sv
// MEM-stage bus bundle: EX/MEM inputs in, MEM/WB outputs back.
// The master drives the pipeline inputs; the slave (mem_access) drives the MEM/WB results.
interface mem_access_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
);
    logic               i_enable;
    logic               i_flush;
    logic [NB_DATA-1:0] i_ALUresult;
    logic [NB_DATA-1:0] i_data2write;
    logic [NB_ADDR-1:0] i_reg2write;
    logic               i_memRead;
    logic               i_memWrite;
    logic [1:0]         i_width;
    logic               i_unsigned;
    logic               i_mem2reg;
    logic               i_regWrite;
    logic [NB_DATA-1:0] o_reg_read;
    logic [NB_DATA-1:0] o_ALUresult;
    logic [NB_ADDR-1:0] o_reg2write;
    logic               o_mem2reg;
    logic               o_regWrite;
    logic               o_misaligned;

    modport master (
        output i_enable, i_flush, i_ALUresult, i_data2write, i_reg2write,
               i_memRead, i_memWrite, i_width, i_unsigned, i_mem2reg, i_regWrite,
        input  o_reg_read, o_ALUresult, o_reg2write, o_mem2reg, o_regWrite, o_misaligned
    );

    modport slave (
        input  i_enable, i_flush, i_ALUresult, i_data2write, i_reg2write,
               i_memRead, i_memWrite, i_width, i_unsigned, i_mem2reg, i_regWrite,
        output o_reg_read, o_ALUresult, o_reg2write, o_mem2reg, o_regWrite, o_misaligned
    );
endinterface

// File: rtl/mem_access.sv
// MIPS MEM stage with the MEM/WB register: byte/half/word loads and stores on a
// little-endian data memory, alignment checking and WB control pass-through.
module mem_access #(
    parameter int NB_DATA      = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_MEM_DEPTH = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_access_if.slave  bus
);
    localparam int NB_IDX = $clog2(NB_MEM_DEPTH);

    // True when the access size does not fit the lane offset.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        logic mis;
        case (width)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] lane);
        logic [3:0] be;
        case (width)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across lanes; byte enables pick the live ones.
    function automatic logic [31:0] place_store(input logic [1:0] width, input logic [31:0] data);
        logic [31:0] w;
        case (width)
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [NB_DATA-1:0] extract_load(input logic [31:0] word,
                                                        input logic [1:0]  lane,
                                                        input logic [1:0]  width,
                                                        input logic        uns);
        logic [31:0]        shifted;
        logic [NB_DATA-1:0] ext;
        shifted = word >> {lane, 3'b000};
        case (width)
            2'b00:   ext = uns ? NB_DATA'(shifted[7:0])  : NB_DATA'($signed(shifted[7:0]));
            2'b01:   ext = uns ? NB_DATA'(shifted[15:0]) : NB_DATA'($signed(shifted[15:0]));
            default: ext = uns ? NB_DATA'(shifted)       : NB_DATA'($signed(shifted));
        endcase
        return ext;
    endfunction

    logic [31:0]        mem_r [NB_MEM_DEPTH];

    logic [NB_IDX-1:0]  word_idx_s;
    logic [1:0]         lane_s;
    logic               misaligned_s;
    logic               wr_en_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_s;
    logic [31:0]        rd_word_s;
    logic [NB_DATA-1:0] load_s;

    logic [NB_DATA-1:0] reg_read_r;
    logic [NB_DATA-1:0] alu_result_r;
    logic [NB_ADDR-1:0] reg2write_r;
    logic               mem2reg_r;
    logic               reg_write_r;
    logic               misaligned_r;

    // Address decode, alignment check, store lane steering and load extraction.
    always_comb begin
        word_idx_s   = bus.i_ALUresult[NB_IDX+1:2];
        lane_s       = bus.i_ALUresult[1:0];
        misaligned_s = (bus.i_memRead | bus.i_memWrite) & is_misaligned(bus.i_width, lane_s);
        wr_en_s      = bus.i_enable & bus.i_memWrite & ~misaligned_s;
        be_s         = byte_enables(bus.i_width, lane_s);
        wdata_s      = place_store(bus.i_width, bus.i_data2write[31:0]);
        rd_word_s    = mem_r[word_idx_s];
        if (bus.i_memRead && !misaligned_s) begin
            load_s = extract_load(rd_word_s, lane_s, bus.i_width, bus.i_unsigned);
        end else begin
            load_s = {NB_DATA{1'b0}};
        end
    end

    // Data memory write port; the array itself is never reset, and writes are blocked during reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB pipeline register: stall holds, flush inserts a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reg_read_r   <= {NB_DATA{1'b0}};
            alu_result_r <= {NB_DATA{1'b0}};
            reg2write_r  <= {NB_ADDR{1'b0}};
            mem2reg_r    <= 1'b0;
            reg_write_r  <= 1'b0;
            misaligned_r <= 1'b0;
        end else if (bus.i_enable) begin
            if (bus.i_flush) begin
                reg_read_r   <= {NB_DATA{1'b0}};
                alu_result_r <= {NB_DATA{1'b0}};
                reg2write_r  <= {NB_ADDR{1'b0}};
                mem2reg_r    <= 1'b0;
                reg_write_r  <= 1'b0;
                misaligned_r <= 1'b0;
            end else begin
                reg_read_r   <= load_s;
                alu_result_r <= bus.i_ALUresult;
                reg2write_r  <= bus.i_reg2write;
                mem2reg_r    <= bus.i_mem2reg;
                reg_write_r  <= bus.i_regWrite;
                misaligned_r <= misaligned_s;
            end
        end else begin
            reg_read_r   <= reg_read_r;
            alu_result_r <= alu_result_r;
            reg2write_r  <= reg2write_r;
            mem2reg_r    <= mem2reg_r;
            reg_write_r  <= reg_write_r;
            misaligned_r <= misaligned_r;
        end
    end

    assign bus.o_reg_read   = reg_read_r;
    assign bus.o_ALUresult  = alu_result_r;
    assign bus.o_reg2write  = reg2write_r;
    assign bus.o_mem2reg    = mem2reg_r;
    assign bus.o_regWrite   = reg_write_r;
    assign bus.o_misaligned = misaligned_r;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected MEM/WB slots are queued as stimulus is
// driven and compared one clock later when the stage produces them.
module tb_mem_access;
    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;

    mem_access_if #(.NB_DATA(32), .NB_ADDR(5)) bus ();

    mem_access #(.NB_DATA(32), .NB_ADDR(5), .NB_MEM_DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  r2w;
        logic        m2r;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".reg_read"},   bus.o_reg_read,                   e.rd);
        chk({tag, ".ALUresult"},  bus.o_ALUresult,                  e.alu);
        chk({tag, ".reg2write"},  {27'd0, bus.o_reg2write},         {27'd0, e.r2w});
        chk({tag, ".mem2reg"},    {31'd0, bus.o_mem2reg},           {31'd0, e.m2r});
        chk({tag, ".regWrite"},   {31'd0, bus.o_regWrite},          {31'd0, e.rw});
        chk({tag, ".misaligned"}, {31'd0, bus.o_misaligned},        {31'd0, e.mis});
    endtask

    task automatic op(input string tag, input logic en, input logic fl,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                      input logic mr, input logic mw, input logic [1:0] w, input logic u,
                      input logic m2r, input logic rw,
                      input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        exp_t got;
        bus.i_enable = en;     bus.i_flush = fl;
        bus.i_ALUresult = alu; bus.i_data2write = wd; bus.i_reg2write = dst;
        bus.i_memRead = mr;    bus.i_memWrite = mw;   bus.i_width = w;
        bus.i_unsigned = u;    bus.i_mem2reg = m2r;   bus.i_regWrite = rw;
        if (!en)     e = last_exp;
        else if (fl) e = '0;
        else         e = '{rd: exp_rd, alu: alu, r2w: dst, m2r: m2r, rw: rw, mis: exp_mis};
        sb_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_outputs(tag, got);
    endtask

    task automatic ld(input string tag, input logic [31:0] addr, input logic [1:0] w,
                      input logic u, input logic [31:0] exp_rd, input logic exp_mis);
        op(tag, 1'b1, 1'b0, addr, 32'h0, 5'd9, 1'b1, 1'b0, w, u, 1'b1, 1'b1, exp_rd, exp_mis);
    endtask

    task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] w, input logic exp_mis);
        op(tag, 1'b1, 1'b0, addr, data, 5'd0, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 32'h0, exp_mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        last_exp = '0;
        rst_n = 1'b0;
        bus.i_enable = 1'b1;      bus.i_flush = 1'b0;
        bus.i_ALUresult = 32'h0000_0040; bus.i_data2write = 32'h0;
        bus.i_reg2write = 5'd3;   bus.i_memRead = 1'b0; bus.i_memWrite = 1'b0;
        bus.i_width = 2'b10;      bus.i_unsigned = 1'b0;
        bus.i_mem2reg = 1'b1;     bus.i_regWrite = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", '0);
        rst_n = 1'b1;

        op("pass", 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 1'b0, 1'b0, 2'b10, 1'b0,
           1'b1, 1'b1, 32'h0, 1'b0);

        st("sw_10",  32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        ld("lw_10",  32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
        ld("lb_13",  32'h13, 2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0);
        ld("lbu_13", 32'h13, 2'b00, 1'b1, 32'h0000_00DE, 1'b0);
        ld("lh_10",  32'h10, 2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0);
        ld("lhu_12", 32'h12, 2'b01, 1'b1, 32'h0000_DEAD, 1'b0);
        st("sb_11",  32'h11, 32'hAAAA_AA55, 2'b00, 1'b0);
        ld("lw_sb",  32'h10, 2'b10, 1'b0, 32'hDEAD_55EF, 1'b0);

        st("sw_mis", 32'h12, 32'h1111_1111, 2'b10, 1'b1);
        ld("lw_nochg", 32'h10, 2'b10, 1'b0, 32'hDEAD_55EF, 1'b0);
        ld("lh_mis", 32'h11, 2'b01, 1'b0, 32'h0, 1'b1);
        ld("lw_mis", 32'h11, 2'b10, 1'b0, 32'h0, 1'b1);
        st("sh_12",  32'h12, 32'h1234_CAFE, 2'b01, 1'b0);
        ld("lw_sh",  32'h10, 2'b10, 1'b0, 32'hCAFE_55EF, 1'b0);

        op("stall1", 1'b0, 1'b0, 32'h10, 32'h0, 5'd1, 1'b0, 1'b1, 2'b10, 1'b0,
           1'b0, 1'b0, 32'h0, 1'b0);
        op("stall2", 1'b0, 1'b0, 32'h10, 32'h0, 5'd1, 1'b0, 1'b1, 2'b10, 1'b0,
           1'b0, 1'b0, 32'h0, 1'b0);
        op("stall_fl", 1'b0, 1'b1, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 2'b10, 1'b0,
           1'b1, 1'b1, 32'h0, 1'b0);
        ld("lw_stall", 32'h10, 2'b10, 1'b0, 32'hCAFE_55EF, 1'b0);

        op("flush_ld", 1'b1, 1'b1, 32'h10, 32'h0, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0,
           1'b1, 1'b1, 32'h0, 1'b0);
        op("flush_st", 1'b1, 1'b1, 32'h14, 32'h7777_7777, 5'd4, 1'b0, 1'b1, 2'b10, 1'b0,
           1'b0, 1'b1, 32'h0, 1'b0);
        ld("lw_14",  32'h14, 2'b10, 1'b0, 32'h7777_7777, 1'b0);

        st("sw_wrap", 32'(4 * DEPTH), 32'hA5A5_A5A5, 2'b10, 1'b0);
        ld("lw_0",   32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0);
        op("rw_0", 1'b1, 1'b0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 2'b10, 1'b0,
           1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        ld("lw_0b",  32'h0, 2'b10, 1'b0, 32'h0, 1'b0);

        st("sw_20",  32'h20, 32'h1234_5678, 2'b10, 1'b0);
        ld("lw_20",  32'h20, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", '0);
        bus.i_enable = 1'b1;  bus.i_flush = 1'b0;
        bus.i_ALUresult = 32'h20; bus.i_data2write = 32'hFFFF_FFFF;
        bus.i_memRead = 1'b0; bus.i_memWrite = 1'b1; bus.i_width = 2'b10;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_exp = '0;
        ld("lw_rst", 32'h20, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
